// File: rtl/i2c_seq_pkg.sv
// Shared encodings for the I2C register sequencer: FSM states, the
// read/write flag, and the length of the master-reset pulse used on abort.
package i2c_seq_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_START   = 4'd1;
    localparam logic [3:0] ST_ADDR    = 4'd2;
    localparam logic [3:0] ST_REG     = 4'd3;
    localparam logic [3:0] ST_DATA    = 4'd4;
    localparam logic [3:0] ST_RDWAIT  = 4'd5;
    localparam logic [3:0] ST_STOP    = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_RECOVER = 4'd8;

    typedef enum logic [3:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        ADDR    = ST_ADDR,
        REG     = ST_REG,
        DATA    = ST_DATA,
        RDWAIT  = ST_RDWAIT,
        STOP    = ST_STOP,
        DONE    = ST_DONE,
        RECOVER = ST_RECOVER
    } state_t;

    localparam logic RW_WRITE       = 1'b0;
    localparam logic RW_READ        = 1'b1;
    localparam int   RECOVER_CYCLES = 4;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin pick: first asserted request at or above the pointer, with wrap.
// The pointer moves to the slot after the last winner when a transaction retires.
module i2c_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    input  logic [PTR_W-1:0] last,
    output logic             valid,
    output logic [PTR_W-1:0] pick
);

    logic [PTR_W-1:0]  ptr;
    logic [2*NREQ-1:0] rot;
    logic [PTR_W:0]    sum;

    always_comb begin
        valid = 1'b0;
        pick  = '0;
        sum   = '0;
        // Rotating the doubled vector puts the pointer slot at bit 0.
        rot   = {req, req} >> ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (PTR_W + 1)'(k);
                if (sum >= (PTR_W + 1)'(NREQ))
                    sum = sum - (PTR_W + 1)'(NREQ);
                pick  = sum[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (last == PTR_W'(NREQ - 1)) ? '0 : last + 1'b1;
    end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Shares one I2C byte master among NREQ clients: arbitrates, runs single-byte
// register writes or current-address reads, and aborts hung transfers.
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 2_000_000,
    parameter int TMO_W   = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [7*NREQ-1:0] req_dev,
    input  logic [8*NREQ-1:0] req_reg,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              m_start,
    input  logic              m_ready,
    output logic              m_send,
    output logic [7:0]        m_datasend,
    input  logic              m_sended,
    output logic              m_receive,
    input  logic [7:0]        m_datareceive,
    input  logic              m_received,
    output logic              m_rst_n
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    state_t           state;
    logic [PTR_W-1:0] win;
    logic             lat_rw;
    logic [7:0]       lat_reg;
    logic [7:0]       lat_wdata;
    logic [TMO_W-1:0] wdog;
    logic [REC_W-1:0] rec_cnt;
    logic             sended_q, received_q, ready_q;

    logic             arb_valid;
    logic [PTR_W-1:0] arb_pick;
    logic             sel_rw;
    logic [6:0]       sel_dev;
    logic [7:0]       sel_reg, sel_wdata;
    logic             sended_rise, received_rise, ready_rise;
    logic             wdog_hit, rec_last, advance;

    i2c_rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .last    (win),
        .valid   (arb_valid),
        .pick    (arb_pick)
    );

    always_comb begin
        sel_rw    = RW_WRITE;
        sel_dev   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_pick == PTR_W'(k)) begin
                sel_rw    = req_rw[k];
                sel_dev   = req_dev[7*k +: 7];
                sel_reg   = req_reg[8*k +: 8];
                sel_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    assign sended_rise   = m_sended & ~sended_q;
    assign received_rise = m_received & ~received_q;
    assign ready_rise    = m_ready & ~ready_q;
    // DONE and RECOVER are already retiring, so the watchdog leaves them alone.
    assign wdog_hit = (wdog == TMO_W'(TIMEOUT - 1)) && (state != IDLE)
                      && (state != DONE) && (state != RECOVER);
    assign rec_last = (state == RECOVER) && (rec_cnt == REC_W'(RECOVER_CYCLES - 1));
    assign advance  = (state == DONE) || rec_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            rdata      <= '0;
            m_start    <= 1'b1;
            m_send     <= 1'b0;
            m_receive  <= 1'b0;
            m_datasend <= '0;
            m_rst_n    <= 1'b1;
            win        <= '0;
            lat_rw     <= RW_WRITE;
            lat_reg    <= '0;
            lat_wdata  <= '0;
            wdog       <= '0;
            rec_cnt    <= '0;
            sended_q   <= 1'b0;
            received_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            sended_q   <= m_sended;
            received_q <= m_received;
            ready_q    <= m_ready;
            done       <= '0;
            if (state != IDLE)
                wdog <= wdog + 1'b1;

            if (wdog_hit) begin
                state     <= RECOVER;
                m_start   <= 1'b1;
                m_send    <= 1'b0;
                m_receive <= 1'b0;
                m_rst_n   <= 1'b0;
                rec_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (m_ready && arb_valid) begin
                        gnt        <= NREQ'(1) << arb_pick;
                        win        <= arb_pick;
                        lat_rw     <= sel_rw;
                        lat_reg    <= sel_reg;
                        lat_wdata  <= sel_wdata;
                        wdog       <= '0;
                        m_start    <= 1'b0;
                        m_datasend <= {sel_dev, sel_rw};
                        state      <= START;
                    end
                    START: if (!m_ready) begin
                        m_start <= 1'b1;
                        state   <= ADDR;
                    end
                    ADDR: if (sended_rise) begin
                        if (lat_rw == RW_READ) begin
                            m_receive <= 1'b0;
                            state     <= RDWAIT;
                        end else begin
                            m_datasend <= lat_reg;
                            m_send     <= 1'b1;
                            state      <= REG;
                        end
                    end
                    REG: begin
                        if (sended_rise) begin
                            m_datasend <= lat_wdata;
                            m_send     <= 1'b1;
                            state      <= DATA;
                        end else if (!m_sended) begin
                            m_send <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (sended_rise) begin
                            m_send <= 1'b0;
                            state  <= STOP;
                        end else if (!m_sended) begin
                            m_send <= 1'b0;
                        end
                    end
                    RDWAIT: if (received_rise) begin
                        rdata <= m_datareceive;
                        state <= STOP;
                    end
                    STOP: if (ready_rise)
                        state <= DONE;
                    DONE: begin
                        done  <= NREQ'(1) << win;
                        err   <= 1'b0;
                        gnt   <= '0;
                        state <= IDLE;
                    end
                    RECOVER: begin
                        if (rec_last) begin
                            m_rst_n <= 1'b1;
                            done    <= NREQ'(1) << win;
                            err     <= 1'b1;
                            gnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            rec_cnt <= rec_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: a behavioural byte-master model records what the
// sequencer sends, and each scenario task compares against expected transfers.
module tb_i2c_reg_sequencer;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 1000;
    localparam int TMO_W   = 21;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [7*NREQ-1:0] req_dev = '0;
    logic [8*NREQ-1:0] req_reg = '0;
    logic [8*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt, done;
    logic              err;
    logic [7:0]        rdata;
    logic              m_start, m_send, m_receive, m_rst_n;
    logic [7:0]        m_datasend;
    logic              m_ready = 1'b1;
    logic              m_sended = 1'b0;
    logic              m_received = 1'b0;
    logic [7:0]        m_datareceive = '0;

    i2c_reg_sequencer #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_dev(req_dev),
        .req_reg(req_reg), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .m_start(m_start), .m_ready(m_ready), .m_send(m_send),
        .m_datasend(m_datasend), .m_sended(m_sended), .m_receive(m_receive),
        .m_datareceive(m_datareceive), .m_received(m_received), .m_rst_n(m_rst_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ptr_ref = 0;

    // Client payloads as the bench posted them.
    logic       c_rw  [NREQ];
    logic [6:0] c_dev [NREQ];
    logic [7:0] c_reg [NREQ];
    logic [7:0] c_wd  [NREQ];

    // Byte-master model: shifts a byte, opens an ack window, continues while send is held.
    int         mst = 0, mcnt = 0, nbytes = 0, nsend_held = 0, ready_cyc = 0;
    logic [7:0] mbytes [4];
    logic       recv_seen = 1'b0;
    logic       hang = 1'b0;
    logic [7:0] rd_val = '0;

    always @(negedge clk) begin
        if (reset || !m_rst_n) begin
            mst = 0; m_ready = 1'b1; m_sended = 1'b0; m_received = 1'b0;
        end else begin
            case (mst)
                0: if (!m_start) begin
                    m_ready = 1'b0; nbytes = 0; nsend_held = 0; recv_seen = 1'b0;
                    mcnt = 3; mst = hang ? 6 : 1;
                end
                1: begin
                    mcnt--;
                    if (mcnt == 0) begin
                        mbytes[nbytes] = m_datasend; nbytes++;
                        m_sended = 1'b1; mcnt = 3; mst = 2;
                    end
                end
                2: begin
                    mcnt--;
                    if (mcnt == 0) begin
                        m_sended = 1'b0;
                        if (nbytes == 1 && mbytes[0][0]) begin mcnt = 4; mst = 3; end
                        else if (m_send && nbytes < 4) begin nsend_held++; mcnt = 3; mst = 1; end
                        else begin mcnt = 2; mst = 5; end
                    end
                end
                3: begin
                    if (m_receive) recv_seen = 1'b1;
                    mcnt--;
                    if (mcnt == 0) begin
                        m_datareceive = rd_val; m_received = 1'b1; mcnt = 2; mst = 4;
                    end
                end
                4: begin
                    mcnt--;
                    if (mcnt == 0) begin m_received = 1'b0; mcnt = 2; mst = 5; end
                end
                5: begin
                    mcnt--;
                    if (mcnt == 0) begin m_ready = 1'b1; ready_cyc = cyc; mst = 0; end
                end
                default: ;
            endcase
        end
    end

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic set_client(input int c, input logic rw, input logic [6:0] dev,
                              input logic [7:0] rg, input logic [7:0] wd);
        c_rw[c] = rw; c_dev[c] = dev; c_reg[c] = rg; c_wd[c] = wd;
        req_rw[c] = rw; req_dev[7*c +: 7] = dev; req_reg[8*c +: 8] = rg; req_wdata[8*c +: 8] = wd;
    endtask

    task automatic wait_done(input int maxc, output logic [NREQ-1:0] d, output logic e,
                             output logic [7:0] rd, output logic [NREQ-1:0] gs,
                             output logic ovl, output int dc, output logic ok);
        d = '0; e = 1'b0; rd = '0; gs = '0; ovl = 1'b0; dc = 0; ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            gs |= gnt;
            if ($countones(gnt) > 1) ovl = 1'b1;
            if (done !== '0) begin d = done; e = err; rd = rdata; dc = cyc; ok = 1'b1; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== '0 || err !== 1'b0 || rdata !== 8'h00) begin
            errors++; $display("FAIL reset_status: gnt=%b done=%b err=%b rdata=%h want 0", gnt, done, err, rdata);
        end
        checks++;
        if (m_start !== 1'b1 || m_send !== 1'b0 || m_receive !== 1'b0 || m_datasend !== 8'h00 || m_rst_n !== 1'b1) begin
            errors++; $display("FAIL reset_master: start=%b send=%b recv=%b ds=%h rst_n=%b want 1 0 0 00 1",
                               m_start, m_send, m_receive, m_datasend, m_rst_n);
        end
        reset = 1'b0; ptr_ref = 0;
        @(negedge clk);
    endtask

    task automatic test_single_write;
        logic [NREQ-1:0] d, gs; logic e, ovl, ok; logic [7:0] rd; int dc;
        set_client(0, 1'b0, 7'h50, 8'h10, 8'hA5);
        req = 2'b01;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01 || m_start !== 1'b0) begin
            errors++; $display("FAIL wr_grant_latency: gnt=%b m_start=%b want 01 0", gnt, m_start);
        end
        wait_done(300, d, e, rd, gs, ovl, dc, ok);
        req = '0;
        checks++;
        if (!ok || d !== 2'b01 || e !== 1'b0) begin
            errors++; $display("FAIL wr_done: ok=%b done=%b err=%b want 1 01 0", ok, d, e);
        end
        checks++;
        if (nbytes !== 3 || mbytes[0] !== 8'hA0 || mbytes[1] !== 8'h10 || mbytes[2] !== 8'hA5) begin
            errors++; $display("FAIL wr_bytes: n=%0d %h %h %h want 3 a0 10 a5", nbytes, mbytes[0], mbytes[1], mbytes[2]);
        end
        checks++;
        if (nsend_held !== 2) begin
            errors++; $display("FAIL wr_send_held: got %0d want 2", nsend_held);
        end
        checks++;
        if (dc - ready_cyc !== 2) begin
            errors++; $display("FAIL wr_done_latency: got %0d want 2", dc - ready_cyc);
        end
        ptr_ref = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read;
        logic [NREQ-1:0] d, gs; logic e, ovl, ok; logic [7:0] rd; int dc;
        set_client(1, 1'b1, 7'h48, 8'h00, 8'h00);
        rd_val = 8'h3C;
        req = 2'b10;
        wait_done(300, d, e, rd, gs, ovl, dc, ok);
        req = '0;
        checks++;
        if (!ok || d !== 2'b10 || e !== 1'b0 || rd !== 8'h3C) begin
            errors++; $display("FAIL rd_done: ok=%b done=%b err=%b rdata=%h want 1 10 0 3c", ok, d, e, rd);
        end
        checks++;
        if (nbytes !== 1 || mbytes[0] !== 8'h91 || recv_seen !== 1'b0) begin
            errors++; $display("FAIL rd_bytes: n=%0d b0=%h recv=%b want 1 91 0", nbytes, mbytes[0], recv_seen);
        end
        ptr_ref = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention;
        logic [NREQ-1:0] d, gs; logic e, ovl, ok; logic [7:0] rd; int dc, w;
        reset = 1'b1;
        for (int c = 0; c < NREQ; c++)
            set_client(c, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));
        rd_val = 8'($urandom);
        @(negedge clk);
        reset = 1'b0; req = 2'b11; ptr_ref = 0;
        for (int t = 0; t < 4; t++) begin
            w = rr_pick(2'b11, ptr_ref);
            wait_done(300, d, e, rd, gs, ovl, dc, ok);
            if (t == 3) req = '0;
            checks++;
            if (!ok || d !== NREQ'(1) << w || gs !== d || ovl !== 1'b0 || e !== 1'b0) begin
                errors++; $display("FAIL cont_order[%0d]: done=%b gnt_seen=%b ovl=%b err=%b want winner %0d",
                                   t, d, gs, ovl, e, w);
            end
            checks++;
            if (mbytes[0] !== {c_dev[w], c_rw[w]} || nbytes !== (c_rw[w] ? 1 : 3) ||
                (!c_rw[w] && (mbytes[1] !== c_reg[w] || mbytes[2] !== c_wd[w])) ||
                (c_rw[w] && rd !== rd_val)) begin
                errors++; $display("FAIL cont_bytes[%0d]: n=%0d %h %h %h rdata=%h want client %0d", t,
                                   nbytes, mbytes[0], mbytes[1], mbytes[2], rd, w);
            end
            ptr_ref = (w + 1) % NREQ;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hung;
        logic ok; int g, bad;
        hang = 1'b1;
        set_client(0, 1'b0, 7'h22, 8'h01, 8'h02);
        req = 2'b01; ok = 1'b0; g = 0; bad = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (gnt !== '0) begin ok = 1'b1; g = cyc; end
        end
        req = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL hung_grant: no grant within 20 cycles"); end
        while (ok && cyc < g + TIMEOUT + 4) begin
            if (m_rst_n !== ((cyc >= g + TIMEOUT && cyc <= g + TIMEOUT + 3) ? 1'b0 : 1'b1)) bad++;
            if (done !== '0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hung_rst_window: %0d bad cycles want 0", bad); end
        checks++;
        if (done !== 2'b01 || err !== 1'b1 || m_rst_n !== 1'b1) begin
            errors++; $display("FAIL hung_abort: done=%b err=%b rst_n=%b want 01 1 1", done, err, m_rst_n);
        end
        hang = 1'b0; ptr_ref = 1;
        @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== '0 || m_start !== 1'b1) begin
            errors++; $display("FAIL hung_idle: gnt=%b done=%b start=%b want 00 00 1", gnt, done, m_start);
        end
    endtask

    task automatic test_reset_mid_data;
        logic [NREQ-1:0] d, gs; logic e, ovl, ok; logic [7:0] rd; int dc;
        set_client(1, 1'b0, 7'h3A, 8'h55, 8'h66);
        req = 2'b10; ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (m_sended && nbytes == 2) ok = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!ok || m_send !== 1'b1 || gnt !== 2'b10) begin
            errors++; $display("FAIL rmd_setup: ok=%b send=%b gnt=%b want 1 1 10", ok, m_send, gnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (gnt !== '0 || m_start !== 1'b1 || m_send !== 1'b0 || done !== '0) begin
            errors++; $display("FAIL rmd_outputs: gnt=%b start=%b send=%b done=%b want 00 1 0 00", gnt, m_start, m_send, done);
        end
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0; ptr_ref = 0;
        set_client(0, 1'b0, 7'h11, 8'h22, 8'h33);
        req = 2'b11;
        wait_done(300, d, e, rd, gs, ovl, dc, ok);
        req = '0;
        checks++;
        if (!ok || d !== 2'b01) begin
            errors++; $display("FAIL rmd_ptr: done=%b want 01", d);
        end
        ptr_ref = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_late_drop;
        logic [NREQ-1:0] d, gs; logic e, ovl, ok; logic [7:0] rd; int dc, n;
        set_client(0, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom));
        req = 2'b01; ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (m_send === 1'b1) ok = 1'b1;
        end
        req = '0;
        wait_done(300, d, e, rd, gs, ovl, dc, ok);
        checks++;
        if (!ok || d !== 2'b01 || e !== 1'b0 || nbytes !== 3 ||
            mbytes[0] !== {c_dev[0], 1'b0} || mbytes[1] !== c_reg[0] || mbytes[2] !== c_wd[0]) begin
            errors++; $display("FAIL drop_complete: done=%b err=%b n=%0d %h %h %h", d, e, nbytes, mbytes[0], mbytes[1], mbytes[2]);
        end
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== '0) n++;
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL drop_single_done: %0d extra pulses want 0", n); end
        ptr_ref = 1;
    endtask

    task automatic test_random;
        logic [NREQ-1:0] d, gs, mask; logic e, ovl, ok; logic [7:0] rd; int dc, w;
        for (int it = 0; it < 12; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int c = 0; c < NREQ; c++)
                set_client(c, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));
            rd_val = 8'($urandom);
            w = rr_pick(mask, ptr_ref);
            req = mask;
            wait_done(300, d, e, rd, gs, ovl, dc, ok);
            req = '0;
            checks++;
            if (!ok || d !== NREQ'(1) << w || e !== 1'b0 || ovl !== 1'b0) begin
                errors++; $display("FAIL rand_winner[%0d]: mask=%b done=%b err=%b want winner %0d", it, mask, d, e, w);
            end
            checks++;
            if (mbytes[0] !== {c_dev[w], c_rw[w]} || nbytes !== (c_rw[w] ? 1 : 3) ||
                (!c_rw[w] && (mbytes[1] !== c_reg[w] || mbytes[2] !== c_wd[w])) ||
                (c_rw[w] && rd !== rd_val)) begin
                errors++; $display("FAIL rand_bytes[%0d]: n=%0d %h %h %h rdata=%h want client %0d", it,
                                   nbytes, mbytes[0], mbytes[1], mbytes[2], rd, w);
            end
            ptr_ref = (w + 1) % NREQ;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_hung();
        test_reset_mid_data();
        test_late_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
